// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Command front-end for an 8-bit universal shift register. It accepts one command
//   per valid/ready handshake and drives the register's d/i/l/r inputs for as many
//   cycles as the command needs. It pulses done in the cycle where q holds the result.
//
//   Register mode {l,r}: 00 hold, 01 shift right (i -> msb), 10 shift left (i -> lsb),
//   11 load d.
//
// Ports
//   c          clock, rising edge
//   rst        synchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  command accepted this cycle if cmd_valid (IDLE and not in reset)
//   cmd_op     000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 CLEAR
//   cmd_cnt    shift count, 0 encodes WIDTH; ignored for NOP/LOAD/CLEAR
//   cmd_data   LOAD operand
//   q_in       register q, fed back for rotate / arithmetic shift fill
//   reg_d      register d
//   reg_i      register serial fill bit
//   reg_l      register l
//   reg_r      register r
//   busy       high in EXEC and DONE
//   done       one-cycle pulse with the final result on q_in
module shift_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                     c,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [$clog2(WIDTH)-1:0] cmd_cnt,
  input  logic [WIDTH-1:0]         cmd_data,
  input  logic [WIDTH-1:0]         q_in,
  output logic [WIDTH-1:0]         reg_d,
  output logic                     reg_i,
  output logic                     reg_l,
  output logic                     reg_r,
  output logic                     busy,
  output logic                     done
);

  localparam int CNTW = $clog2(WIDTH) + 1;  // must hold WIDTH itself

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHL   = 3'b010,
    OP_SHR   = 3'b011,
    OP_ROL   = 3'b100,
    OP_ROR   = 3'b101,
    OP_ASR   = 3'b110,
    OP_CLEAR = 3'b111
  } op_e;

  state_e           r_state;
  op_e              r_op;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_d;
  logic             r_l;
  logic             r_r;
  logic             r_busy;
  logic             r_done;

  logic [CNTW-1:0]  w_cnt_n;
  logic             w_accept;

  assign cmd_ready = (r_state == IDLE) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;
  // A count field of zero means a full-width shift.
  assign w_cnt_n   = (cmd_cnt == '0) ? CNTW'(WIDTH) : {1'b0, cmd_cnt};

  always_ff @(posedge c) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= OP_NOP;
      r_cnt   <= '0;
      r_d     <= '0;
      r_l     <= 1'b0;
      r_r     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_op   <= op_e'(cmd_op);
            r_busy <= 1'b1;
            r_d    <= '0;
            case (op_e'(cmd_op))
              OP_NOP: begin
                // Nothing to drive: go straight to the done pulse.
                r_state <= DONE;
                r_done  <= 1'b1;
              end
              OP_LOAD: begin
                r_state <= EXEC;
                r_cnt   <= CNTW'(1);
                r_d     <= cmd_data;
                {r_l, r_r} <= 2'b11;
              end
              OP_CLEAR: begin
                r_state <= EXEC;
                r_cnt   <= CNTW'(1);
                {r_l, r_r} <= 2'b11;
              end
              OP_SHL, OP_ROL: begin
                r_state <= EXEC;
                r_cnt   <= w_cnt_n;
                {r_l, r_r} <= 2'b10;
              end
              default: begin  // SHR, ROR, ASR
                r_state <= EXEC;
                r_cnt   <= w_cnt_n;
                {r_l, r_r} <= 2'b01;
              end
            endcase
          end
        end
        EXEC: begin
          // The register acts on every edge leaving an EXEC cycle, so the
          // edge where the count reaches 1 is the last active one.
          if (r_cnt == CNTW'(1)) begin
            r_state    <= DONE;
            r_done     <= 1'b1;
            {r_l, r_r} <= 2'b00;
          end else begin
            r_cnt <= r_cnt - CNTW'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          {r_l, r_r} <= 2'b00;
        end
      endcase
    end
  end

  // Fill bit follows live q so every step of a multi-cycle rotate or ASR
  // uses the current edge bit.
  always_comb begin
    reg_i = 1'b0;
    case (r_op)
      OP_ROL, OP_ASR: reg_i = q_in[WIDTH-1];
      OP_ROR:         reg_i = q_in[0];
      default:        reg_i = 1'b0;
    endcase
  end

  assign reg_d = r_d;
  assign reg_l = r_l;
  assign reg_r = r_r;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural universal register
// closing the q feedback loop.
module tb_shift_sequencer;

  localparam logic [2:0] NOP = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                         ROL = 3'b100, ROR = 3'b101, ASR = 3'b110, CLR = 3'b111;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_cnt;
  logic [7:0] cmd_data;
  logic [7:0] q = 8'h00;
  logic [7:0] reg_d;
  logic       reg_i, reg_l, reg_r, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(8)) dut (
    .c(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .q_in(q),
    .reg_d(reg_d), .reg_i(reg_i), .reg_l(reg_l), .reg_r(reg_r),
    .busy(busy), .done(done)
  );

  // Universal register: no reset, mode {l,r}.
  always @(posedge clk) begin
    case ({reg_l, reg_r})
      2'b01:   q <= {reg_i, q[7:1]};
      2'b10:   q <= {q[6:0], reg_i};
      2'b11:   q <= reg_d;
      default: q <= q;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a command, wait for done (bounded), check latency, then return to IDLE.
  task automatic run(input string tag, input logic [2:0] op, input logic [2:0] cnt,
                     input logic [7:0] data, input int lat);
    int cyc;
    chk({tag, "_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; cmd_data = data;
    tick();
    cmd_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_done"}, done, 1);
    tick();
    chk({tag, "_idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cmd_cnt = 3'd0; cmd_data = 8'h00;

    // Reset
    tick(); tick();
    chk("rst_lr", {reg_l, reg_r}, 2'b00);
    chk("rst_busy_done", {busy, done}, 2'b00);
    chk("rst_ready_low", cmd_ready, 0);
    rst = 1'b0; #1;
    chk("rel_ready", cmd_ready, 1);

    // LOAD 0xA5, step by step
    cmd_valid = 1'b1; cmd_op = LOAD; cmd_data = 8'hA5;
    tick(); cmd_valid = 1'b0;
    chk("load_lr", {reg_l, reg_r}, 2'b11);
    chk("load_d", reg_d, 8'hA5);
    chk("load_busy", {busy, done, cmd_ready}, 3'b100);
    tick();
    chk("load_done", {done, reg_l, reg_r}, 3'b100);
    chk("load_q", q, 8'hA5);
    tick();
    chk("load_idle", {busy, done, cmd_ready}, 3'b001);

    // SHL 3 on 0xA5 with a CLEAR offered while busy
    cmd_valid = 1'b1; cmd_op = SHL; cmd_cnt = 3'd3;
    tick();
    cmd_op = CLR;
    chk("shl_lr1", {reg_l, reg_r, reg_i}, 3'b100);
    chk("shl_ready_busy", cmd_ready, 0);
    tick();
    chk("shl_lr2", {reg_l, reg_r, busy}, 3'b101);
    tick();
    chk("shl_lr3", {reg_l, reg_r, done}, 3'b100);
    cmd_valid = 1'b0;
    tick();
    chk("shl_done", done, 1);
    chk("shl_q", q, 8'h28);
    tick();
    chk("shl_no_clear", q, 8'h28);
    chk("shl_idle", busy, 0);

    // Rotates
    run("ld81a", LOAD, 3'd0, 8'h81, 2);
    run("ror1", ROR, 3'd1, 8'h00, 2);
    chk("ror1_q", q, 8'hC0);
    run("ld81b", LOAD, 3'd0, 8'h81, 2);
    run("rol8", ROL, 3'd0, 8'h00, 9);
    chk("rol8_q", q, 8'h81);

    // Arithmetic shift
    run("ld90", LOAD, 3'd0, 8'h90, 2);
    run("asr2", ASR, 3'd2, 8'h00, 3);
    chk("asr2_q", q, 8'hE4);
    run("ld80", LOAD, 3'd0, 8'h80, 2);
    run("asr8", ASR, 3'd0, 8'h00, 9);
    chk("asr8_q", q, 8'hFF);

    // Full-width logical shift, CLEAR, NOP
    run("shr8", SHR, 3'd0, 8'h00, 9);
    chk("shr8_q", q, 8'h00);
    run("ld5a", LOAD, 3'd0, 8'h5A, 2);
    run("nop", NOP, 3'd5, 8'hFF, 1);
    chk("nop_q", q, 8'h5A);
    run("clr", CLR, 3'd3, 8'hFF, 2);
    chk("clr_q", q, 8'h00);

    // Reset during SHR 5 on 0xA5
    run("lda5", LOAD, 3'd0, 8'hA5, 2);
    cmd_valid = 1'b1; cmd_op = SHR; cmd_cnt = 3'd5;
    tick(); cmd_valid = 1'b0;
    tick();
    chk("shr_mid_q", q, 8'h52);
    rst = 1'b1;
    tick();
    chk("shr_rst_lr", {reg_l, reg_r}, 2'b00);
    chk("shr_rst_flags", {busy, done, cmd_ready}, 3'b000);
    chk("shr_rst_q", q, 8'h29);
    rst = 1'b0; #1;
    chk("shr_rel_ready", cmd_ready, 1);
    tick();
    chk("shr_hold", {done, q}, {1'b0, 8'h29});

    // Reset and valid together: not accepted
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = LOAD; cmd_data = 8'h33;
    #1;
    chk("rv_ready", cmd_ready, 0);
    tick();
    cmd_valid = 1'b0; rst = 1'b0;
    chk("rv_state", {busy, reg_l, reg_r}, 3'b000);
    tick();
    chk("rv_q", q, 8'h29);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
